// File: rtl/corelet_ctrl_pkg.sv
// rtl/corelet_ctrl_pkg.sv - shared states, MAC instruction codes and timing helper for the corelet sequencer
package corelet_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_W_FILL,
      ST_W_LOAD,
      ST_X_FILL,
      ST_EXEC,
      ST_DRAIN,
      ST_DONE
   } ctrl_state_t;

   localparam logic [1:0] INST_NOP  = 2'b00;
   localparam logic [1:0] INST_LOAD = 2'b01;
   localparam logic [1:0] INST_EXEC = 2'b10;

   localparam int CNT_W = 16;

   // Cycles for freshly loaded weights to ripple through the whole array.
   function automatic int CTRL_IDLE_WAIT(input int row, input int col);
      return row + col;
   endfunction

endpackage

// File: rtl/corelet_ctrl_if.sv
// rtl/corelet_ctrl_if.sv - sequencer <-> corelet datapath signal bundle (CORELET_CTRL_PERF_EN adds counters)
interface corelet_ctrl_if #(
   parameter int a_bw = 11,
   parameter int p_bw = 11
);
   logic            start;
   logic [a_bw-1:0] w_base;
   logic [a_bw-1:0] x_base;
   logic            l0_full;
   logic            l0_ready;
   logic            ofifo_valid;
   logic            sram_cen;
   logic            sram_wen;
   logic [a_bw-1:0] sram_a;
   logic            l0_wr;
   logic            l0_rd;
   logic [1:0]      inst;
   logic            ofifo_rd;
   logic            psum_cen;
   logic            psum_wen;
   logic [p_bw-1:0] psum_a;
   logic            busy;
   logic            done;
`ifdef CORELET_CTRL_PERF_EN
   logic [31:0]     stall_cnt;
   logic [31:0]     cycle_cnt;
`endif

   modport master (
      input  start, w_base, x_base, l0_full, l0_ready, ofifo_valid,
      output sram_cen, sram_wen, sram_a, l0_wr, l0_rd, inst,
      output ofifo_rd, psum_cen, psum_wen, psum_a, busy, done
`ifdef CORELET_CTRL_PERF_EN
      , output stall_cnt, cycle_cnt
`endif
   );

   modport slave (
      output start, w_base, x_base, l0_full, l0_ready, ofifo_valid,
      input  sram_cen, sram_wen, sram_a, l0_wr, l0_rd, inst,
      input  ofifo_rd, psum_cen, psum_wen, psum_a, busy, done
`ifdef CORELET_CTRL_PERF_EN
      , input stall_cnt, cycle_cnt
`endif
   );

endinterface

// File: rtl/corelet_ctrl_step_counter.sv
// rtl/corelet_ctrl_step_counter.sv - up counter with clear/load/enable and terminal-count flag
module ctrl_step_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic [W-1:0] last,
   output logic [W-1:0] count,
   output logic         tc
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

   assign tc = (count == last);

endmodule

// File: rtl/corelet_ctrl.sv
// rtl/corelet_ctrl.sv - corelet layer sequencer: weight fill/load, activation fill, execute, psum drain
// Optional CORELET_CTRL_PERF_EN adds stall_cnt/cycle_cnt on the interface.
module corelet_ctrl
   import corelet_ctrl_pkg::*;
#(
   parameter int row     = 8,
   parameter int col     = 8,
   parameter int bw      = 4,
   parameter int len_kij = 9,
   parameter int len_nij = 36,
   parameter int a_bw    = 11,
   parameter int p_bw    = 11
) (
   input logic            clk,
   input logic            reset,
   corelet_ctrl_if.master bus
);

   localparam int LOAD_LAST = col + CTRL_IDLE_WAIT(row, col) - 1;

   // Operand width belongs to the datapath; nothing to sequence on it here.
   if (bw < 1) begin : g_bw_unused
   end

   ctrl_state_t      state, state_n;
   logic [CNT_W-1:0] cnt, kij, cnt_last;
   logic             cnt_tc, kij_tc;
   logic             cnt_clr, cnt_en, kij_clr, kij_en;
   logic             accept, stall;
   logic [a_bw-1:0]  w_base_q, x_base_q;

   logic             cen_d, wr_d, rd_d, ofifo_rd_d, pcen_d, pwen_d, busy_d, done_d;
   logic [1:0]       inst_d;
   logic [a_bw-1:0]  sram_a_d;
   logic [p_bw-1:0]  psum_a_d;

   ctrl_step_counter #(.W(CNT_W)) u_inner (
      .clk(clk), .reset(reset), .clear(cnt_clr), .load(1'b0), .load_val('0),
      .en(cnt_en), .last(cnt_last), .count(cnt), .tc(cnt_tc)
   );

   ctrl_step_counter #(.W(CNT_W)) u_kij (
      .clk(clk), .reset(reset), .clear(kij_clr), .load(1'b0), .load_val('0),
      .en(kij_en), .last(CNT_W'(len_kij - 1)), .count(kij), .tc(kij_tc)
   );

   always_comb begin
      cnt_last = '0;
      case (state)
         ST_W_FILL:                   cnt_last = CNT_W'(col - 1);
         ST_W_LOAD:                   cnt_last = CNT_W'(LOAD_LAST);
         ST_X_FILL, ST_EXEC, ST_DRAIN: cnt_last = CNT_W'(len_nij - 1);
         default:                     cnt_last = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n    = state;
      cnt_clr    = 1'b0;
      cnt_en     = 1'b0;
      kij_clr    = 1'b0;
      kij_en     = 1'b0;
      accept     = 1'b0;
      stall      = 1'b0;
      cen_d      = 1'b1;
      wr_d       = 1'b0;
      rd_d       = 1'b0;
      inst_d     = INST_NOP;
      ofifo_rd_d = 1'b0;
      pcen_d     = 1'b1;
      pwen_d     = 1'b1;
      sram_a_d   = '0;
      psum_a_d   = '0;
      done_d     = 1'b0;
      busy_d     = (state != ST_IDLE);
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               accept  = 1'b1;
               busy_d  = 1'b1;
               cnt_clr = 1'b1;
               kij_clr = 1'b1;
               state_n = ST_W_FILL;
            end
         end
         ST_W_FILL: begin
            if (bus.l0_full) begin
               stall = 1'b1;
            end else begin
               cen_d    = 1'b0;
               wr_d     = 1'b1;
               sram_a_d = w_base_q + a_bw'(kij) * a_bw'(col) + a_bw'(cnt);
               cnt_en   = 1'b1;
               if (cnt_tc) begin
                  cnt_clr = 1'b1;
                  state_n = ST_W_LOAD;
               end
            end
         end
         ST_W_LOAD: begin
            // First col steps push weights into the array; the rest only let them settle.
            if (cnt < CNT_W'(col) && !bus.l0_ready) begin
               stall = 1'b1;
            end else begin
               if (cnt < CNT_W'(col)) begin
                  rd_d   = 1'b1;
                  inst_d = INST_LOAD;
               end
               cnt_en = 1'b1;
               if (cnt_tc) begin
                  cnt_clr = 1'b1;
                  state_n = ST_X_FILL;
               end
            end
         end
         ST_X_FILL: begin
            if (bus.l0_full) begin
               stall = 1'b1;
            end else begin
               cen_d    = 1'b0;
               wr_d     = 1'b1;
               sram_a_d = x_base_q + a_bw'(cnt);
               cnt_en   = 1'b1;
               if (cnt_tc) begin
                  cnt_clr = 1'b1;
                  state_n = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            if (!bus.l0_ready) begin
               stall = 1'b1;
            end else begin
               rd_d   = 1'b1;
               inst_d = INST_EXEC;
               cnt_en = 1'b1;
               if (cnt_tc) begin
                  cnt_clr = 1'b1;
                  state_n = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (!bus.ofifo_valid) begin
               stall = 1'b1;
            end else begin
               ofifo_rd_d = 1'b1;
               pcen_d     = 1'b0;
               pwen_d     = 1'b0;
               psum_a_d   = p_bw'(kij) * p_bw'(len_nij) + p_bw'(cnt);
               cnt_en     = 1'b1;
               if (cnt_tc) begin
                  cnt_clr = 1'b1;
                  if (kij_tc) begin
                     state_n = ST_DONE;
                  end else begin
                     kij_en  = 1'b1;
                     state_n = ST_W_FILL;
                  end
               end
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.sram_cen <= 1'b1;
         bus.sram_a   <= '0;
         bus.l0_wr    <= 1'b0;
         bus.l0_rd    <= 1'b0;
         bus.inst     <= INST_NOP;
         bus.ofifo_rd <= 1'b0;
         bus.psum_cen <= 1'b1;
         bus.psum_wen <= 1'b1;
         bus.psum_a   <= '0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         w_base_q     <= '0;
         x_base_q     <= '0;
      end else begin
         bus.sram_cen <= cen_d;
         bus.sram_a   <= sram_a_d;
         bus.l0_wr    <= wr_d;
         bus.l0_rd    <= rd_d;
         bus.inst     <= inst_d;
         bus.ofifo_rd <= ofifo_rd_d;
         bus.psum_cen <= pcen_d;
         bus.psum_wen <= pwen_d;
         bus.psum_a   <= psum_a_d;
         bus.busy     <= busy_d;
         bus.done     <= done_d;
         if (accept) begin
            w_base_q <= bus.w_base;
            x_base_q <= bus.x_base;
         end
      end
   end

   assign bus.sram_wen = 1'b1;

`ifdef CORELET_CTRL_PERF_EN
   // cycle_cnt tracks the registered busy flag so it matches what the datapath sees.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.stall_cnt <= '0;
         bus.cycle_cnt <= '0;
      end else if (accept) begin
         bus.stall_cnt <= '0;
         bus.cycle_cnt <= '0;
      end else begin
         if (stall && bus.stall_cnt != '1)
            bus.stall_cnt <= bus.stall_cnt + 1'b1;
         if (bus.busy && bus.cycle_cnt != '1)
            bus.cycle_cnt <= bus.cycle_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_corelet_ctrl.sv
// tb/tb_corelet_ctrl.sv - directed self-checking bench for corelet_ctrl (CORELET_CTRL_PERF_EN aware)
module tb_corelet_ctrl;
   import corelet_ctrl_pkg::*;

   localparam int ROW = 8, COL = 8, BW = 4, LEN_KIJ = 2, LEN_NIJ = 4, A_BW = 11, P_BW = 11;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   corelet_ctrl_if #(.a_bw(A_BW), .p_bw(P_BW)) bus ();

   corelet_ctrl #(
      .row(ROW), .col(COL), .bw(BW), .len_kij(LEN_KIJ), .len_nij(LEN_NIJ),
      .a_bw(A_BW), .p_bw(P_BW)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Output monitor, sampled on the falling edge.
   int cyc = 0, done_cnt = 0, wr_cnt = 0, rd_cnt = 0, load_cnt = 0, exec_cnt = 0;
   int ord_cnt = 0, ord_bad = 0, wr_bad = 0, pw_bad = 0, busy_cyc = 0;
   logic prev_ofv = 1'b0;
   logic [A_BW-1:0] sram_log[$];
   int              sram_cyc[$];
   logic [P_BW-1:0] psum_log[$];

   always @(negedge clk) begin
      cyc++;
      if (!bus.sram_cen) begin
         sram_log.push_back(bus.sram_a);
         sram_cyc.push_back(cyc);
      end
      if (bus.l0_wr) wr_cnt++;
      if (bus.l0_wr == bus.sram_cen) wr_bad++;
      if (bus.l0_rd) rd_cnt++;
      if (bus.inst == INST_LOAD) load_cnt++;
      if (bus.inst == INST_EXEC) exec_cnt++;
      if (bus.ofifo_rd) begin
         ord_cnt++;
         if (!prev_ofv) ord_bad++;
         psum_log.push_back(bus.psum_a);
      end
      if (bus.ofifo_rd == bus.psum_cen || bus.psum_cen != bus.psum_wen) pw_bad++;
      if (bus.done) done_cnt++;
      if (bus.busy) busy_cyc++;
      prev_ofv = bus.ofifo_valid;
   end

   int s_sram, s_psum, s_wr, s_rd, s_load, s_exec, s_ord, s_ordbad, s_wrbad, s_pwbad, s_done, s_busy;

   task automatic snap();
      s_sram = sram_log.size(); s_psum = psum_log.size();
      s_wr = wr_cnt; s_rd = rd_cnt; s_load = load_cnt; s_exec = exec_cnt;
      s_ord = ord_cnt; s_ordbad = ord_bad; s_wrbad = wr_bad; s_pwbad = pw_bad;
      s_done = done_cnt; s_busy = busy_cyc;
   endtask

   task automatic start_layer(input logic [A_BW-1:0] wb, input logic [A_BW-1:0] xb);
      @(posedge clk); #1;
      bus.w_base = wb; bus.x_base = xb; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.w_base = ~wb; bus.x_base = ~xb;
   endtask

   task automatic wait_done(input bit tog, input int maxc);
      int d0 = done_cnt;
      int n  = 0;
      while (done_cnt == d0 && n < maxc) begin
         @(posedge clk); #1;
         if (tog) bus.ofifo_valid = ~bus.ofifo_valid;
         n++;
      end
      chk("done_timeout", n < maxc, 1);
      bus.ofifo_valid = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   task automatic check_layer(input logic [A_BW-1:0] wb, input logic [A_BW-1:0] xb, input int exp_gap);
      int k = s_sram;
      logic [A_BW-1:0] got;
      logic [P_BW-1:0] pgot;
      chk("sram_reads", sram_log.size() - s_sram, LEN_KIJ * (COL + LEN_NIJ));
      for (int kij = 0; kij < LEN_KIJ; kij++) begin
         for (int i = 0; i < COL; i++) begin
            got = (k < sram_log.size()) ? sram_log[k] : 'x;
            chk("w_addr", got, A_BW'(wb + kij * COL + i));
            k++;
         end
         for (int i = 0; i < LEN_NIJ; i++) begin
            got = (k < sram_log.size()) ? sram_log[k] : 'x;
            chk("x_addr", got, A_BW'(xb + i));
            k++;
         end
      end
      chk("fill_gap", (sram_cyc.size() >= s_sram + COL) ?
          sram_cyc[s_sram + COL - 1] - sram_cyc[s_sram] - (COL - 1) : -1, exp_gap);
      chk("psum_writes", psum_log.size() - s_psum, LEN_KIJ * LEN_NIJ);
      for (int j = 0; j < LEN_KIJ * LEN_NIJ; j++) begin
         pgot = (s_psum + j < psum_log.size()) ? psum_log[s_psum + j] : 'x;
         chk("psum_addr", pgot, j);
      end
      chk("l0_wr_cnt", wr_cnt - s_wr, LEN_KIJ * (COL + LEN_NIJ));
      chk("l0_rd_cnt", rd_cnt - s_rd, LEN_KIJ * (COL + LEN_NIJ));
      chk("load_cnt", load_cnt - s_load, LEN_KIJ * COL);
      chk("exec_cnt", exec_cnt - s_exec, LEN_KIJ * LEN_NIJ);
      chk("ofifo_rd_cnt", ord_cnt - s_ord, LEN_KIJ * LEN_NIJ);
      chk("rd_wo_valid", ord_bad - s_ordbad, 0);
      chk("wr_cen_pair", wr_bad - s_wrbad, 0);
      chk("psum_pair", pw_bad - s_pwbad, 0);
      chk("done_pulses", done_cnt - s_done, 1);
      chk("idle_after", bus.busy, 0);
   endtask

   int n;

   initial begin
      bus.start = 1'b1; bus.w_base = '0; bus.x_base = '0;
      bus.l0_full = 1'b0; bus.l0_ready = 1'b1; bus.ofifo_valid = 1'b1;
      #1 reset = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("rst_outs", {bus.sram_cen, bus.sram_wen, bus.psum_cen, bus.psum_wen, bus.busy,
                       bus.inst, bus.done, bus.l0_wr, bus.l0_rd, bus.ofifo_rd},
          {4'b1111, 7'b0000000});
      @(posedge clk); #1;
      reset = 1'b0; bus.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_start_ignored", bus.busy, 0);

      // Nominal layer with a stray start pulse mid-run.
      snap();
      start_layer(11'h010, 11'h040);
      repeat (20) @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      wait_done(1'b0, 1000);
      check_layer(11'h010, 11'h040, 0);
      chk("busy_extra", busy_cyc - s_busy <= 200, 1);

      // Three cycles of l0_full during the first weight fill.
      snap();
      start_layer(11'h010, 11'h040);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(bus.sram_cen == 1'b0 && bus.sram_a == 11'h013) && n < 200);
      chk("stall_arm", n < 200, 1);
      @(posedge clk); #1 bus.l0_full = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus.l0_full = 1'b0;
      wait_done(1'b0, 1000);
      check_layer(11'h010, 11'h040, 3);
`ifdef CORELET_CTRL_PERF_EN
      chk("stall_cnt", bus.stall_cnt, 3);
      chk("cycle_cnt", bus.cycle_cnt, busy_cyc - s_busy);
`endif

      // ofifo_valid toggling, bases chosen so addresses wrap past 0x7FF.
      snap();
      start_layer(11'h7FC, 11'h7FE);
      wait_done(1'b1, 1000);
      check_layer(11'h7FC, 11'h7FE, 0);

      // Reset while executing.
      snap();
      start_layer(11'h010, 11'h040);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.inst != INST_EXEC && n < 300);
      chk("exec_reached", n < 300, 1);
      @(posedge clk); #1 reset = 1'b1;
      #1;
      chk("rst_exec_outs", {bus.sram_cen, bus.sram_wen, bus.psum_cen, bus.psum_wen, bus.busy,
                            bus.inst, bus.done, bus.l0_wr, bus.l0_rd, bus.ofifo_rd},
          {4'b1111, 7'b0000000});
      chk("rst_exec_addr", {21'b0, bus.sram_a, bus.psum_a}, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (10) @(negedge clk);
      chk("rst_exec_idle", bus.busy, 0);
      chk("rst_exec_no_done", done_cnt - s_done, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
